// File: rtl/i2c_clk_generation.sv
// I2C SCL generator: divides clk into a 50/50 SCL waveform with
// edge and mid-phase strobes, hold/finish modes and clock stretching.
module i2c_clk_generation #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] clk_status,
  input  logic       scl_in,
  output logic       scl_out,
  output logic       scl_fall,
  output logic       scl_rise,
  output logic       mid_low,
  output logic       mid_high,
  output logic       busy
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(CLK_DIV);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t C_HALF = cnt_t'(HALF);
  localparam cnt_t C_LAST = cnt_t'(CLK_DIV - 1);
  localparam cnt_t C_ML   = cnt_t'(HALF / 2);
  localparam cnt_t C_MH   = cnt_t'(HALF + HALF / 2);
  localparam cnt_t C_STR  = cnt_t'(HALF + 1);
  localparam cnt_t C_ONE  = cnt_t'(1);

  localparam logic [1:0] CS_IDLE = 2'b00;
  localparam logic [1:0] CS_HOLD = 2'b01;
  localparam logic [1:0] CS_RUN  = 2'b10;
  localparam logic [1:0] CS_FIN  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_state_n;
  cnt_t   r_cnt;
  cnt_t   w_cnt_n;
  cnt_t   w_cnt_inc;
  logic   r_scl;
  logic   w_scl_n;
  logic   r_fall;
  logic   w_fall_n;
  logic   r_rise;
  logic   w_rise_n;
  logic   r_ml;
  logic   w_ml_n;
  logic   r_mh;
  logic   w_mh_n;
  logic   r_sync1;
  logic   r_sync2;
  logic   w_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= scl_in;
      r_sync2 <= r_sync1;
    end
  end

  // The slave may hold SCL low just after we release it.
  assign w_stall   = r_scl && (r_cnt == C_STR) && !r_sync2;
  assign w_cnt_inc = (r_cnt == C_LAST) ? '0 : r_cnt + C_ONE;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_scl_n   = r_scl;
    w_fall_n  = 1'b0;
    w_rise_n  = 1'b0;
    w_ml_n    = 1'b0;
    w_mh_n    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        w_scl_n = 1'b1;
        if (clk_status == CS_RUN) begin
          w_state_n = S_RUN;
          w_scl_n   = 1'b0;
          w_fall_n  = 1'b1;
        end else if (clk_status == CS_HOLD) begin
          w_state_n = S_HOLD;
          w_scl_n   = 1'b0;
          w_fall_n  = 1'b1;
        end
      end
      S_HOLD: begin
        w_scl_n = 1'b0;
        if (clk_status == CS_RUN) begin
          w_state_n = S_RUN;
          w_cnt_n   = '0;
        end else if (clk_status != CS_HOLD) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
          w_scl_n   = 1'b1;
          w_rise_n  = 1'b1;
        end
      end
      default: begin
        unique case (clk_status)
          CS_IDLE: begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
            w_scl_n   = 1'b1;
            w_rise_n  = !r_scl;
          end
          CS_HOLD: begin
            w_state_n = S_HOLD;
            w_scl_n   = 1'b0;
            w_fall_n  = r_scl;
          end
          default: begin
            w_state_n = (clk_status == CS_FIN) ? S_FIN : S_RUN;
            if (!w_stall) begin
              if (clk_status == CS_FIN && r_cnt == C_LAST) begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
                w_scl_n   = 1'b1;
              end else begin
                w_cnt_n  = w_cnt_inc;
                w_scl_n  = (w_cnt_inc >= C_HALF);
                w_fall_n = (w_cnt_inc == '0);
                w_rise_n = (w_cnt_inc == C_HALF);
                w_ml_n   = (w_cnt_inc == C_ML);
                w_mh_n   = (w_cnt_inc == C_MH);
              end
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_scl   <= 1'b1;
      r_fall  <= 1'b0;
      r_rise  <= 1'b0;
      r_ml    <= 1'b0;
      r_mh    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_scl   <= w_scl_n;
      r_fall  <= w_fall_n;
      r_rise  <= w_rise_n;
      r_ml    <= w_ml_n;
      r_mh    <= w_mh_n;
    end
  end

  assign scl_out  = r_scl;
  assign scl_fall = r_fall;
  assign scl_rise = r_rise;
  assign mid_low  = r_ml;
  assign mid_high = r_mh;
  assign busy     = (r_state == S_RUN) || (r_state == S_FIN);

endmodule

// File: tb/tb_i2c_clk_generation.sv
// Bench for i2c_clk_generation: directed steps plus random modes and
// stretching, checked against a phase-position reference model.
module tb_i2c_clk_generation;

  localparam int CLK_DIV = 8;
  localparam int HALF    = CLK_DIV / 2;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;
  localparam int M_FIN  = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] clk_status = 2'b00;
  logic       scl_in = 1'b1;
  logic       scl_out;
  logic       scl_fall;
  logic       scl_rise;
  logic       mid_low;
  logic       mid_high;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int m_mode;
  int m_pos;
  bit m_scl;
  bit m_fall;
  bit m_rise;
  bit m_ml;
  bit m_mh;
  bit dly[$];

  always #5 clk = ~clk;

  i2c_clk_generation #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk_status(clk_status),
    .scl_in    (scl_in),
    .scl_out   (scl_out),
    .scl_fall  (scl_fall),
    .scl_rise  (scl_rise),
    .mid_low   (mid_low),
    .mid_high  (mid_high),
    .busy      (busy)
  );

  function void mdl_reset();
    m_mode = M_IDLE;
    m_pos  = 0;
    m_scl  = 1'b1;
    m_fall = 1'b0;
    m_rise = 1'b0;
    m_ml   = 1'b0;
    m_mh   = 1'b0;
    dly    = {1'b1, 1'b1};
  endfunction

  function bit m_busy();
    return (m_mode == M_RUN) || (m_mode == M_FIN);
  endfunction

  // Reference: SCL level follows the position within the period;
  // edge strobes are just changes of the expected level.
  function void mdl_edge();
    bit syn;
    bit adv;
    bit prev;
    int s;
    if (!reset_n) begin
      mdl_reset();
      return;
    end
    s    = int'(clk_status);
    syn  = dly.pop_front();
    dly.push_back(scl_in);
    prev = m_scl;
    adv  = 1'b0;
    if (m_mode == M_IDLE) begin
      m_pos = 0;
      if (s == 2) m_mode = M_RUN;
      else if (s == 1) m_mode = M_HOLD;
    end else if (m_mode == M_HOLD) begin
      if (s == 2) begin
        m_mode = M_RUN;
        m_pos  = 0;
      end else if (s != 1) begin
        m_mode = M_IDLE;
        m_pos  = 0;
      end
    end else begin
      if (s == 0) begin
        m_mode = M_IDLE;
        m_pos  = 0;
      end else if (s == 1) begin
        m_mode = M_HOLD;
      end else begin
        m_mode = (s == 3) ? M_FIN : M_RUN;
        if (m_pos == HALF + 1 && !syn) begin
          adv = 1'b0;
        end else if (s == 3 && m_pos == CLK_DIV - 1) begin
          m_mode = M_IDLE;
          m_pos  = 0;
        end else begin
          m_pos = (m_pos + 1) % CLK_DIV;
          adv   = 1'b1;
        end
      end
    end
    if (m_busy()) m_scl = (m_pos >= HALF);
    else m_scl = (m_mode != M_HOLD);
    m_fall = prev && !m_scl;
    m_rise = !prev && m_scl;
    m_ml   = adv && (m_pos == HALF / 2);
    m_mh   = adv && (m_pos == HALF + HALF / 2);
  endfunction

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {scl_out, scl_fall, scl_rise, mid_low, mid_high, busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    mdl_edge();
    #1;
    check(tag, {m_scl, m_fall, m_rise, m_ml, m_mh, m_busy()});
  endtask

  task automatic seek(input int p);
    int n;
    n = 0;
    while (!(m_busy() && m_pos == p) && n < 64) begin
      step("seek");
      n++;
    end
    check_int("seek_bound", int'(n < 64), 1);
  endtask

  initial begin
    int ph;
    int mh_cnt;
    int r;
    mdl_reset();
    #2 reset_n = 1'b0;
    #1 check("reset", 6'b100000);
    step("rst_hold");
    step("rst_hold");
    reset_n = 1'b1;
    step("idle");
    step("idle");

    clk_status = 2'b10;
    for (int k = 1; k <= 80; k++) begin
      step("run");
      ph = (k - 1) % CLK_DIV;
      check("wave", {ph >= 4, ph == 0, ph == 4,
                     ph == 2, ph == 6, 1'b1});
    end

    seek(2);
    #3 reset_n = 1'b0;
    #1 mdl_reset();
    check("async_rst", 6'b100000);
    step("rst_run");
    step("rst_run");
    reset_n = 1'b1;
    repeat (12) step("rerun");

    seek(HALF - 2);
    scl_in = 1'b0;
    mh_cnt = 0;
    repeat (20) begin
      step("stretch");
      mh_cnt += int'(mid_high);
    end
    check_int("stretch_no_mh", mh_cnt, 0);
    scl_in = 1'b1;
    mh_cnt = 0;
    repeat (8) begin
      step("unstretch");
      mh_cnt += int'(mid_high);
    end
    check_int("stretch_mh", mh_cnt, 1);

    seek(2);
    clk_status = 2'b11;
    repeat (16) step("finish");
    check("finish_end", 6'b100000);

    clk_status = 2'b10;
    seek(5);
    clk_status = 2'b01;
    step("hold_enter");
    check_int("hold_fall", int'(scl_fall), 1);
    repeat (50) step("hold");
    clk_status = 2'b10;
    repeat (12) step("hold_exit");

    seek(1);
    clk_status = 2'b00;
    step("abort");
    check("abort_edge", 6'b101000);
    repeat (4) step("abort_idle");

    clk_status = 2'b10;
    repeat (800) begin
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 5);
        clk_status = (r < 3) ? 2'b10 : 2'(r - 3);
      end
      if (scl_in && $urandom_range(0, 29) == 0) scl_in = 1'b0;
      else if (!scl_in && $urandom_range(0, 7) == 0) scl_in = 1'b1;
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
